// File: rtl/serial_port_ctrl_pkg.sv
// Shared definitions for the serial port controller: SFR operation codes,
// SCON bit addresses and FSM state encodings.
package serial_port_ctrl_pkg;

  localparam int SFR_OP_LEN = 2;
  localparam logic [SFR_OP_LEN-1:0] OP_NONE        = 2'd0;
  localparam logic [SFR_OP_LEN-1:0] OP_SCON_WR_BIT = 2'd2;

  // SCON bit addresses as seen by the SFR bit-write path
  localparam logic [2:0] SCON_ADDR_RI  = 3'd0;
  localparam logic [2:0] SCON_ADDR_TI  = 3'd1;
  localparam logic [2:0] SCON_ADDR_RB8 = 3'd2;

  // Bit positions inside the SCON byte
  localparam int SCON_SM0 = 7;
  localparam int SCON_SM1 = 6;
  localparam int SCON_SM2 = 5;
  localparam int SCON_REN = 4;
  localparam int SCON_RI  = 0;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [7:0] scon_bit_wr(input logic [2:0] addr, input logic val);
    return {4'b0000, addr, val};
  endfunction

endpackage

// File: rtl/serial_rx.sv
// Mode-1 receiver: start detection, mid-bit sampling, shift register and
// frame acceptance against RI/SM2.
module serial_rx import serial_port_ctrl_pkg::*; #(
  parameter int OVS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_baud_tick,
  input  logic       i_rxd,
  input  logic       i_en,
  input  logic       i_sm2,
  input  logic       i_ri,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_done
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

  rx_state_t    r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [7:0]    r_rx_byte;
  logic          w_mid, w_last, w_accept;

  assign w_mid  = i_baud_tick && (r_cnt == CNT_MID);
  assign w_last = i_baud_tick && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_accept     = 1'b0;
    if (!i_en) begin
      w_state_next = RX_IDLE;
      w_cnt_next   = '0;
      w_bit_next   = '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          // The detecting tick is tick 0 of the start bit
          if (i_baud_tick && !i_rxd) begin
            w_state_next = RX_START;
            w_cnt_next   = CW'(1);
            w_bit_next   = '0;
          end
        end
        RX_START: begin
          if (i_baud_tick) w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
          if (w_mid && i_rxd) begin
            w_state_next = RX_IDLE;
            w_cnt_next   = '0;
          end else if (w_last) begin
            w_state_next = RX_DATA;
          end
        end
        RX_DATA: begin
          if (i_baud_tick) w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
          if (w_mid) w_shift_next = {i_rxd, r_shift[7:1]};
          if (w_last) begin
            w_bit_next = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_next = RX_STOP;
          end
        end
        RX_STOP: begin
          if (i_baud_tick) w_cnt_next = r_cnt + 1'b1;
          if (w_mid) begin
            w_state_next = RX_IDLE;
            w_cnt_next   = '0;
            w_accept     = !i_ri && (!i_sm2 || i_rxd);
          end
        end
        default: w_state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx_byte <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      if (w_accept) r_rx_byte <= r_shift;
    end
  end

  assign o_rx_byte = r_rx_byte;
  assign o_rx_done = w_accept;

endmodule

// File: rtl/serial_port_ctrl.sv
// Mode-1 serial port: transmitter FSM, receiver instance and the single-port
// SCON bit-write arbiter (RB8 > RI > TI).
module serial_port_ctrl import serial_port_ctrl_pkg::*; #(
  parameter int OVS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_baud_tick,
  input  logic [7:0]            i_scon,
  input  logic                  i_sbuf_wr,
  input  logic [7:0]            i_sbuf_data,
  input  logic                  i_rxd,
  output logic                  o_txd,
  output logic [7:0]            o_rx_byte,
  output logic [SFR_OP_LEN-1:0] o_scon_op,
  output logic [7:0]            o_scon_byte,
  output logic                  o_tx_busy
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

  logic w_mode1, w_rx_done, w_ti_event, w_tick_last;
  logic w_scon_unused;

  assign w_mode1       = !i_scon[SCON_SM0] && i_scon[SCON_SM1];
  assign w_scon_unused = &{1'b0, i_scon[3:1]};

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_state, w_tx_state_next;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]    r_tx_bit, w_tx_bit_next;
  logic [7:0]    r_tx_shift, w_tx_shift_next;

  assign w_tick_last = i_baud_tick && (r_tx_cnt == CNT_LAST);

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_bit_next   = r_tx_bit;
    w_tx_shift_next = r_tx_shift;
    w_ti_event      = 1'b0;
    if (r_tx_state != TX_IDLE && !w_mode1) begin
      w_tx_state_next = TX_IDLE;
      w_tx_cnt_next   = '0;
      w_tx_bit_next   = '0;
    end else begin
      if (r_tx_state != TX_IDLE && i_baud_tick)
        w_tx_cnt_next = w_tick_last ? '0 : r_tx_cnt + 1'b1;
      case (r_tx_state)
        TX_IDLE: begin
          if (i_sbuf_wr && w_mode1) begin
            w_tx_state_next = TX_START;
            w_tx_shift_next = i_sbuf_data;
            w_tx_cnt_next   = '0;
            w_tx_bit_next   = '0;
          end
        end
        TX_START: if (w_tick_last) w_tx_state_next = TX_DATA;
        TX_DATA: begin
          if (w_tick_last) begin
            w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_next   = r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) w_tx_state_next = TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tick_last) begin
            w_tx_state_next = TX_IDLE;
            w_ti_event      = 1'b1;
          end
        end
        default: w_tx_state_next = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_shift <= w_tx_shift_next;
    end
  end

  always_comb begin
    case (r_tx_state)
      TX_START: o_txd = 1'b0;
      TX_DATA:  o_txd = r_tx_shift[0];
      default:  o_txd = 1'b1;
    endcase
  end

  assign o_tx_busy = (r_tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  serial_rx #(.OVS(OVS)) u_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_baud_tick (i_baud_tick),
    .i_rxd       (i_rxd),
    .i_en        (w_mode1 && i_scon[SCON_REN]),
    .i_sm2       (i_scon[SCON_SM2]),
    .i_ri        (i_scon[SCON_RI]),
    .o_rx_byte   (o_rx_byte),
    .o_rx_done   (w_rx_done)
  );

  // ---------------- SCON write arbitration ----------------
  // Request slots: [0]=RB8, [1]=RI, [2]=TI, lowest index wins
  logic [2:0] r_pend, w_event, w_grant;
  logic       r_rb8_val;

  assign w_event    = {w_ti_event, w_rx_done, w_rx_done};
  assign w_grant[0] = r_pend[0];
  assign w_grant[1] = r_pend[1] & ~r_pend[0];
  assign w_grant[2] = r_pend[2] & ~(|r_pend[1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend    <= '0;
      r_rb8_val <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++)
        r_pend[i] <= (r_pend[i] & ~w_grant[i]) | w_event[i];
      if (w_rx_done) r_rb8_val <= i_rxd;
    end
  end

  always_comb begin
    o_scon_op   = OP_NONE;
    o_scon_byte = 8'h00;
    if (|r_pend) begin
      o_scon_op = OP_SCON_WR_BIT;
      if (w_grant[0])      o_scon_byte = scon_bit_wr(SCON_ADDR_RB8, r_rb8_val);
      else if (w_grant[1]) o_scon_byte = scon_bit_wr(SCON_ADDR_RI, 1'b1);
      else                 o_scon_byte = scon_bit_wr(SCON_ADDR_TI, 1'b1);
    end
  end

endmodule
